// File: rtl/modadd_prefix_pipe_if.sv
// Handshake and data bundle between the hashed/enveloped cell rows and the
// prefix/select back end of the modular adder.
interface modadd_prefix_pipe_if #(
  parameter int N_bits = 7
);

  logic              in_valid;
  logic              in_ready;
  logic [N_bits-1:0] gi;
  logic [N_bits-1:0] pi;
  logic [N_bits-1:0] hi;
  logic [N_bits-1:0] gi_prim;
  logic [N_bits-1:0] pi_prim;
  logic [N_bits-1:0] hi_prim;
  logic              bpi1_msb;
  logic              out_valid;
  logic              out_ready;
  logic [N_bits-1:0] sum;
  logic              wrap;

  // Producer of the row vectors and consumer of the sum.
  modport master (
    output in_valid, gi, pi, hi, gi_prim, pi_prim, hi_prim, bpi1_msb, out_ready,
    input  in_ready, out_valid, sum, wrap
  );

  // The adder back end.
  modport slave (
    input  in_valid, gi, pi, hi, gi_prim, pi_prim, hi_prim, bpi1_msb, out_ready,
    output in_ready, out_valid, sum, wrap
  );

endinterface

// File: rtl/modadd_prefix_pipe.sv
// Pipelined back end of the modular adder. Two Kogge-Stone carry networks run
// side by side, one prefix level per register stage: one for A+B (from the
// hashed-row g/p/h) and one for A+B+K (from the enveloped-row g'/p'/h'). A final
// register stage picks the K-adjusted sum whenever A+B+K carries past 2^N, which
// is exactly the A+B >= M case. Every stage is elastic: it loads when empty or
// when the stage after it is taking its current contents.
module modadd_prefix_pipe #(
  parameter int N_bits = 7,
  parameter int STAGES = $clog2(N_bits)
) (
  input  logic                 clk,
  input  logic                 rst,
  modadd_prefix_pipe_if.slave  bus
);

  // Both networks' (G,P), both half-sum rows, and the 2^N-weight b' bit.
  typedef struct packed {
    logic [N_bits-1:0] g;
    logic [N_bits-1:0] p;
    logic [N_bits-1:0] gp;
    logic [N_bits-1:0] pp;
    logic [N_bits-1:0] h;
    logic [N_bits-1:0] hp;
    logic              msb;
  } stage_t;

  stage_t            st_q   [STAGES];
  stage_t            stg_in [STAGES];
  stage_t            st_d   [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vin;
  logic [STAGES:0]   take;

  logic              out_valid_q;
  logic [N_bits-1:0] sum_q;
  logic              wrap_q;

  logic [N_bits-1:0] carry;
  logic [N_bits-1:0] carry_p;
  logic [N_bits-1:0] s1;
  logic [N_bits-1:0] s2;
  logic              co2;
  logic [N_bits-1:0] sum_d;

  // One Kogge-Stone level at span d for the generate vector.
  function automatic logic [N_bits-1:0] pfx_g(input logic [N_bits-1:0] g,
                                              input logic [N_bits-1:0] p,
                                              input int d);
    logic [N_bits-1:0] r;
    r = g;
    for (int i = 0; i < N_bits; i++) begin
      if (i >= d) r[i] = g[i] | (p[i] & g[i-d]);
    end
    return r;
  endfunction

  // One Kogge-Stone level at span d for the propagate vector.
  function automatic logic [N_bits-1:0] pfx_p(input logic [N_bits-1:0] p,
                                              input int d);
    logic [N_bits-1:0] r;
    r = p;
    for (int i = 0; i < N_bits; i++) begin
      if (i >= d) r[i] = p[i] & p[i-d];
    end
    return r;
  endfunction

  // Load enables, walked back from the output: a stage may load when it is
  // empty or when its occupant moves forward this cycle.
  always_comb begin
    take = '0;
    take[STAGES] = !out_valid_q || bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = !vld_q[k] || take[k+1];
    end
  end

  assign bus.in_ready = take[0];

  // Source of each stage: the bus for stage 0, the previous register otherwise.
  always_comb begin
    stg_in[0].g   = bus.gi;
    stg_in[0].p   = bus.pi;
    stg_in[0].gp  = bus.gi_prim;
    stg_in[0].pp  = bus.pi_prim;
    stg_in[0].h   = bus.hi;
    stg_in[0].hp  = bus.hi_prim;
    stg_in[0].msb = bus.bpi1_msb;
    vin[0]        = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k] = st_q[k-1];
      vin[k]    = vld_q[k-1];
    end
  end

  // Prefix level k (span 2^k) applied to both networks; h rows ride along.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]    = stg_in[k];
      st_d[k].g  = pfx_g(stg_in[k].g, stg_in[k].p, 1 << k);
      st_d[k].p  = pfx_p(stg_in[k].p, 1 << k);
      st_d[k].gp = pfx_g(stg_in[k].gp, stg_in[k].pp, 1 << k);
      st_d[k].pp = pfx_p(stg_in[k].pp, 1 << k);
    end
  end

  // Prefix stage registers; data only captured for a real (valid) arrival so
  // bubbles leave the previous contents untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) vld_q[k] <= vin[k];
        if (take[k] && vin[k]) st_q[k] <= st_d[k];
      end
    end
  end

  // Final sum select: the carry into bit i is the group generate of bits
  // [i-1:0]; co2 is the 2^N carry of A+B+K, i.e. A+B >= M.
  always_comb begin
    carry   = {st_q[STAGES-1].g[N_bits-2:0], 1'b0};
    carry_p = {st_q[STAGES-1].gp[N_bits-2:0], 1'b0};
    s1      = st_q[STAGES-1].h ^ carry;
    s2      = st_q[STAGES-1].hp ^ carry_p;
    co2     = st_q[STAGES-1].msb | st_q[STAGES-1].gp[N_bits-1];
    sum_d   = co2 ? s2 : s1;
  end

  // Output register; holds sum/wrap while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      wrap_q      <= 1'b0;
    end else if (take[STAGES]) begin
      out_valid_q <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        sum_q  <= sum_d;
        wrap_q <= co2;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_modadd_prefix_pipe.sv
// Bench for modadd_prefix_pipe at N=7, K=20 (M=108). The hashed and enveloped
// rows are built here from the operands; expected results come from integer
// arithmetic and are queued on acceptance, popped on output.
module tb_modadd_prefix_pipe;

  localparam int N   = 7;
  localparam int M   = 108;
  localparam int K   = 20;
  localparam int STG = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modadd_prefix_pipe_if #(.N_bits(N)) ifc ();

  modadd_prefix_pipe #(.N_bits(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [N-1:0] sum;
    logic         wrap;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int s;
    int w;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int accepted = 0;
  int produced = 0;
  bit took, gave;
  bit stall_prev = 0;
  logic [N-1:0] hold_sum;
  logic hold_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Hashed row: 3:2 compress A,B,K into a' and b'; enveloped row then forms
  // g'/p'/h' of a' + 2*b', with b'_{N-1} carrying weight 2^N.
  task automatic drive_rows(input int a, input int b);
    logic [N-1:0] av, bv, kv, ap, bp, bs;
    av = a[N-1:0];
    bv = b[N-1:0];
    kv = K[N-1:0];
    ap = av ^ bv ^ kv;
    bp = (av & bv) | (av & kv) | (bv & kv);
    bs = {bp[N-2:0], 1'b0};
    ifc.gi       = av & bv;
    ifc.pi       = av | bv;
    ifc.hi       = av ^ bv;
    ifc.gi_prim  = ap & bs;
    ifc.pi_prim  = ap | bs;
    ifc.hi_prim  = ap ^ bs;
    ifc.bpi1_msb = bp[N-1];
  endtask

  // One clock: drive at the falling edge, then look at what the next rising
  // edge will transfer.
  task automatic step(input bit iv, input int a, input int b, input bit ordy);
    exp_t e;
    @(negedge clk);
    ifc.in_valid  = iv;
    drive_rows(a, b);
    ifc.out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("hold_valid", ifc.out_valid, 1);
      check("hold_sum", ifc.sum, hold_sum);
      check("hold_wrap", ifc.wrap, hold_wrap);
    end
    took = iv && ifc.in_ready;
    gave = ifc.out_valid && ordy;
    if (took) begin
      e.sum  = 7'((a + b) % M);
      e.wrap = (a + b) >= M;
      sb.push_back(e);
      accepted++;
    end
    if (gave) begin
      produced++;
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_sum", ifc.sum, e.sum);
        check("sb_wrap", ifc.wrap, e.wrap);
      end
    end
    stall_prev = ifc.out_valid && !ordy;
    hold_sum   = ifc.sum;
    hold_wrap  = ifc.wrap;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step(0, 0, 0, 1);
      n++;
    end
    check("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int lat, a, b, acc0, prod0, drops, cyc;
    bit seen;

    vt[0] = '{a: 69,  b: 45,  s: 6,   w: 1};
    vt[1] = '{a: 10,  b: 20,  s: 30,  w: 0};
    vt[2] = '{a: 107, b: 107, s: 106, w: 1};
    vt[3] = '{a: 54,  b: 54,  s: 0,   w: 1};
    vt[4] = '{a: 0,   b: 107, s: 107, w: 0};

    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    drive_rows(0, 0);
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_sum", ifc.sum, 0);
    check("rst_wrap", ifc.wrap, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", ifc.in_ready, 1);

    // Directed vectors with latency measurement.
    for (int i = 0; i < 5; i++) begin
      step(1, vt[i].a, vt[i].b, 1);
      check("dir_accept", took, 1);
      lat = 0;
      seen = 0;
      while (!seen && lat < 20) begin
        step(0, 0, 0, 1);
        lat++;
        if (gave) begin
          seen = 1;
          check("dir_sum", ifc.sum, vt[i].s);
          check("dir_wrap", ifc.wrap, vt[i].w);
        end
      end
      check("dir_latency", lat, STG + 1);
    end

    // Back-to-back full throughput.
    prod0 = produced;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, $urandom_range(0, M - 1), $urandom_range(0, M - 1), 1);
      if (!took) drops++;
    end
    check("b2b_in_ready_drops", drops, 0);
    check("b2b_throughput", produced - prod0, 50 - (STG + 1));
    drain(20);

    // Backpressure: fill with out_ready low, then release.
    acc0 = accepted;
    for (int i = 0; i < 12; i++) begin
      step(1, $urandom_range(0, M - 1), $urandom_range(0, M - 1), 0);
      if (!ifc.in_ready) break;
    end
    check("bp_count", accepted - acc0, STG + 1);
    check("bp_in_ready", ifc.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2, 0);
      check("bp_hold_ready", ifc.in_ready, 0);
    end
    check("bp_queue", sb.size(), STG + 1);
    step(1, 100, 7, 1);
    check("bp_release_ready", ifc.in_ready, 1);
    prod0 = produced;
    drain(20);
    check("bp_drain_count", produced - prod0, STG + 1);

    // Random valid/ready toggling.
    acc0 = accepted;
    cyc = 0;
    while (accepted - acc0 < 200 && cyc < 3000) begin
      a = $urandom_range(0, M - 1);
      b = $urandom_range(0, M - 1);
      step($urandom_range(0, 9) >= 3, a, b, $urandom_range(0, 9) >= 3);
      cyc++;
    end
    check("rand_accepted", accepted - acc0, 200);
    drain(100);

    // Asynchronous reset with three entries in flight.
    step(1, 100, 50, 0);
    step(1, 30, 40, 0);
    step(1, 60, 10, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("pre_rst_valid", ifc.out_valid, 1);
    check("pre_rst_sum", ifc.sum, 42);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", ifc.out_valid, 0);
    check("mid_rst_sum", ifc.sum, 0);
    check("mid_rst_wrap", ifc.wrap, 0);
    sb.delete();
    stall_prev = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 5, 6, 1);
    check("post_rst_accept", took, 1);
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      step(0, 0, 0, 1);
      lat++;
      if (gave) begin
        seen = 1;
        check("post_rst_sum", ifc.sum, 11);
      end
    end
    check("post_rst_latency", lat, STG + 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("post_rst_no_stale", ifc.out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
